tmr_scrub_reg: RTL and testbench

Triplicated (M-modular) storage register that produces the redundant copies a majority voter consumes. It accepts writes through a valid/ready handshake and fans the data out to M copies. It periodically scrubs the copies by rewriting all of them with their bitwise majority, and it counts the scrubs that corrected a disagreement. It sits upstream of the voter in readout TMR paths: `rep_o` connects directly to the voter's packed input vector.

---
 rtl/tmr_scrub_reg.sv | 177 +++++++++++++++++
 tb/tb_tmr_scrub_reg.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_scrub_reg.sv
// M-way redundant storage register with periodic majority scrubbing and a saturating correction counter.
// Defining TMR_SCRUB_FAULT_INJ_EN adds the inj_* fault-injection ports.
module tmr_scrub_reg #(
    parameter int M            = 3,
    parameter int N            = 4,
    parameter int SCRUB_PERIOD = 256,
    parameter int CNT_W        = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_valid_i,
    input  logic [N-1:0]         wr_data_i,
    output logic                 wr_ready_o,
    output logic [M*N-1:0]       rep_o,
    output logic [N-1:0]         voted_o,
    output logic                 mismatch_o,
    output logic                 scrub_busy_o,
    output logic [CNT_W-1:0]     err_cnt_o,
    input  logic                 err_cnt_clr_i
`ifdef TMR_SCRUB_FAULT_INJ_EN
    ,
    input  logic                 inj_valid_i,
    input  logic [$clog2(M)-1:0] inj_copy_i,
    input  logic [N-1:0]         inj_mask_i
`endif
);

    // One spare timer bit keeps the replication widths below non-zero for small periods.
    localparam int TW = $clog2(SCRUB_PERIOD) + 1;
    localparam logic [TW-1:0]    TIMER_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0]    TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0]    TIMER_LAST = TW'(SCRUB_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SCRUB_EVAL = 2'd1,
        SCRUB_FIX  = 2'd2
    } state_t;

    function automatic logic [N-1:0] maj_vote(input logic [M*N-1:0] rep);
        logic [N-1:0] v;
        int           ones;
        v = {N{1'b0}};
        for (int b = 0; b < N; b++) begin
            ones = 32'sd0;
            for (int h = 0; h < M; h++) begin
                ones = ones + int'(rep[h*N + b]);
            end
            v[b] = (ones > (M >> 1));
        end
        return v;
    endfunction

    function automatic logic any_disagree(input logic [M*N-1:0] rep);
        logic d;
        int   ones;
        d = 1'b0;
        for (int b = 0; b < N; b++) begin
            ones = 32'sd0;
            for (int h = 0; h < M; h++) begin
                ones = ones + int'(rep[h*N + b]);
            end
            d = d | ((ones > 32'sd0) && (ones < M));
        end
        return d;
    endfunction

    state_t             state_r;
    logic [TW-1:0]      timer_r;
    logic               ready_r;
    logic [M*N-1:0]     copies_r;
    logic [N-1:0]       voted_r;
    logic               mism_r;
    logic [CNT_W-1:0]   err_cnt_r;

    logic [M*N-1:0]     copies_nxt_s;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               cnt_inc_s;
    logic               wr_fire_s;
    logic [N-1:0]       voted_s;
    logic               mism_s;

    assign voted_s      = maj_vote(copies_r);
    assign mism_s       = any_disagree(copies_r);
    assign wr_fire_s    = wr_valid_i & ready_r;

    assign rep_o        = copies_r;
    assign voted_o      = voted_s;
    assign mismatch_o   = mism_s;
    assign wr_ready_o   = ready_r;
    assign scrub_busy_o = ~ready_r;
    assign err_cnt_o    = err_cnt_r;

    // Next copy contents: write or scrub fix, then any injected flip on top.
    always_comb begin
        copies_nxt_s = copies_r;
        if (wr_fire_s) begin
            copies_nxt_s = {M{wr_data_i}};
        end else if ((state_r == SCRUB_FIX) && mism_r) begin
            copies_nxt_s = {M{voted_r}};
        end else begin
            copies_nxt_s = copies_r;
        end
`ifdef TMR_SCRUB_FAULT_INJ_EN
        for (int h = 0; h < M; h++) begin
            if (inj_valid_i && (inj_copy_i == ($clog2(M))'(h))) begin
                copies_nxt_s[h*N +: N] = copies_nxt_s[h*N +: N] ^ inj_mask_i;
            end else begin
                copies_nxt_s[h*N +: N] = copies_nxt_s[h*N +: N];
            end
        end
`endif
    end

    // Corrected-scrub counter: saturating, clear wins but keeps a coincident increment.
    always_comb begin
        cnt_inc_s = (state_r == SCRUB_FIX) && mism_r;
        cnt_nxt_s = err_cnt_r;
        if (err_cnt_clr_i) begin
            if (cnt_inc_s) begin
                cnt_nxt_s = CNT_ONE;
            end else begin
                cnt_nxt_s = CNT_ZERO;
            end
        end else if (cnt_inc_s && !(&err_cnt_r)) begin
            cnt_nxt_s = err_cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = err_cnt_r;
        end
    end

    // Scrub FSM with idle timer, storage copies and counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            timer_r   <= TIMER_ZERO;
            ready_r   <= 1'b1;
            copies_r  <= {(M*N){1'b0}};
            voted_r   <= {N{1'b0}};
            mism_r    <= 1'b0;
            err_cnt_r <= CNT_ZERO;
        end else begin
            copies_r  <= copies_nxt_s;
            err_cnt_r <= cnt_nxt_s;
            case (state_r)
                IDLE: begin
                    if (wr_fire_s) begin
                        timer_r <= TIMER_ZERO;
                    end else if (timer_r == TIMER_LAST) begin
                        timer_r <= TIMER_ZERO;
                        state_r <= SCRUB_EVAL;
                        ready_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                SCRUB_EVAL: begin
                    voted_r <= voted_s;
                    mism_r  <= mism_s;
                    state_r <= SCRUB_FIX;
                end
                SCRUB_FIX: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    timer_r <= TIMER_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmr_scrub_reg.sv
// Scoreboard bench for tmr_scrub_reg (M=3, N=4, SCRUB_PERIOD=8, CNT_W=2).
// Injection scenarios are built only when TMR_SCRUB_FAULT_INJ_EN is defined.
module tb_tmr_scrub_reg;

    localparam int P = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wr_valid_i;
    logic [3:0]  wr_data_i;
    logic        wr_ready_o;
    logic [11:0] rep_o;
    logic [3:0]  voted_o;
    logic        mismatch_o;
    logic        scrub_busy_o;
    logic [1:0]  err_cnt_o;
    logic        err_cnt_clr_i;
`ifdef TMR_SCRUB_FAULT_INJ_EN
    logic        inj_valid_i;
    logic [1:0]  inj_copy_i;
    logic [3:0]  inj_mask_i;
`endif

    logic        inj_v;
    logic [1:0]  inj_c;
    logic [3:0]  inj_m;

    always #5 clk_i = ~clk_i;

    tmr_scrub_reg #(.M(3), .N(4), .SCRUB_PERIOD(P), .CNT_W(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_valid_i   (wr_valid_i),
        .wr_data_i    (wr_data_i),
        .wr_ready_o   (wr_ready_o),
        .rep_o        (rep_o),
        .voted_o      (voted_o),
        .mismatch_o   (mismatch_o),
        .scrub_busy_o (scrub_busy_o),
        .err_cnt_o    (err_cnt_o),
        .err_cnt_clr_i(err_cnt_clr_i)
`ifdef TMR_SCRUB_FAULT_INJ_EN
        ,
        .inj_valid_i  (inj_valid_i),
        .inj_copy_i   (inj_copy_i),
        .inj_mask_i   (inj_mask_i)
`endif
    );

    typedef struct packed {
        logic [11:0] rep;
        logic [3:0]  vote;
        logic        mis;
        logic        rdy;
        logic        busy;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (phase 0 idle, 1 eval, 2 fix).
    logic [3:0] mc [3];
    int         mphase;
    int         mtimer;
    int         mcnt;
    logic [3:0] mhv;
    logic       mhm;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] tb_vote(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic tb_mis(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return |((a ^ b) | (a ^ c));
    endfunction

    task automatic model_step(input logic rst, input logic wv, input logic [3:0] wd, input logic clr);
        logic       fire;
        logic       inc;
        logic [3:0] o0, o1, o2;
        if (rst) begin
            mc[0] = 4'h0; mc[1] = 4'h0; mc[2] = 4'h0;
            mphase = 0; mtimer = 0; mcnt = 0; mhv = 4'h0; mhm = 1'b0;
        end else begin
            o0 = mc[0]; o1 = mc[1]; o2 = mc[2];
            fire = wv && (mphase == 0);
            inc  = (mphase == 2) && mhm;
            if (fire) begin
                mc[0] = wd; mc[1] = wd; mc[2] = wd;
            end else if (inc) begin
                mc[0] = mhv; mc[1] = mhv; mc[2] = mhv;
            end
            if (inj_v && (inj_c < 2'd3)) mc[inj_c] = mc[inj_c] ^ inj_m;
            if (clr) mcnt = inc ? 1 : 0;
            else if (inc && (mcnt < 3)) mcnt++;
            case (mphase)
                0: begin
                    if (fire) mtimer = 0;
                    else if (mtimer == P - 1) begin
                        mtimer = 0;
                        mphase = 1;
                    end else mtimer++;
                end
                1: begin
                    mhv    = tb_vote(o0, o1, o2);
                    mhm    = tb_mis(o0, o1, o2);
                    mphase = 2;
                end
                default: mphase = 0;
            endcase
        end
    endtask

    task automatic cycle(input logic rst, input logic wv, input logic [3:0] wd, input logic clr);
        exp_t e;
        rst_i         = rst;
        wr_valid_i    = wv;
        wr_data_i     = wd;
        err_cnt_clr_i = clr;
`ifdef TMR_SCRUB_FAULT_INJ_EN
        inj_valid_i = inj_v;
        inj_copy_i  = inj_c;
        inj_mask_i  = inj_m;
`endif
        model_step(rst, wv, wd, clr);
        e.rep  = {mc[2], mc[1], mc[0]};
        e.vote = tb_vote(mc[0], mc[1], mc[2]);
        e.mis  = tb_mis(mc[0], mc[1], mc[2]);
        e.rdy  = (mphase == 0);
        e.busy = (mphase != 0);
        e.cnt  = 2'(mcnt);
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        check_eq("rep", 32'(rep_o), 32'(e.rep));
        check_eq("voted", 32'(voted_o), 32'(e.vote));
        check_eq("mismatch", 32'(mismatch_o), 32'(e.mis));
        check_eq("wr_ready", 32'(wr_ready_o), 32'(e.rdy));
        check_eq("scrub_busy", 32'(scrub_busy_o), 32'(e.busy));
        check_eq("err_cnt", 32'(err_cnt_o), 32'(e.cnt));
        inj_v = 1'b0;
    endtask

    task automatic idle1();
        cycle(1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic wait_phase(input int p);
        int g;
        g = 0;
        while ((mphase != p) && (g < 40)) begin
            idle1();
            g++;
        end
        check_eq("wait_phase_bound", 32'(g < 40), 32'd1);
        check_eq("busy_at_phase", 32'(scrub_busy_o), 32'(p != 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_busy;
        int busy_cycles;
        int gap;
        int g;
        rst_i = 1'b1; wr_valid_i = 1'b0; wr_data_i = 4'h0; err_cnt_clr_i = 1'b0;
        inj_v = 1'b0; inj_c = 2'd0; inj_m = 4'h0;
`ifdef TMR_SCRUB_FAULT_INJ_EN
        inj_valid_i = 1'b0; inj_copy_i = 2'd0; inj_mask_i = 4'h0;
`endif
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        check_eq("rst_rep", 32'(rep_o), 32'd0);
        check_eq("rst_ready", 32'(wr_ready_o), 32'd1);

        // Cadence: cycle 1 is the first cycle after the reset edge.
        first_busy  = 0;
        busy_cycles = 0;
        for (int k = 1; k <= 29; k++) begin
            idle1();
            if (scrub_busy_o && (first_busy == 0)) first_busy = k + 1;
            if (scrub_busy_o && (k + 1 <= 20)) busy_cycles++;
        end
        check_eq("first_scrub_cycle", 32'(first_busy), 32'd9);
        check_eq("busy_cycles_1_20", 32'(busy_cycles), 32'd4);
        check_eq("cnt_no_err", 32'(err_cnt_o), 32'd0);

        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        cycle(1'b0, 1'b1, 4'hA, 1'b0);
        check_eq("wrA_rep", 32'(rep_o), 32'h0000_0AAA);
        check_eq("wrA_vote", 32'(voted_o), 32'hA);
        check_eq("wrA_mis", 32'(mismatch_o), 32'd0);

        // Write on the timer-expiry cycle beats the scrub.
        g = 0;
        while (!((mphase == 0) && (mtimer == P - 1)) && (g < 40)) begin
            idle1();
            g++;
        end
        check_eq("timer_wait_bound", 32'(g < 40), 32'd1);
        cycle(1'b0, 1'b1, 4'h7, 1'b0);
        check_eq("exp_no_scrub", 32'(scrub_busy_o), 32'd0);
        check_eq("exp_rep", 32'(rep_o), 32'h0000_0777);
        gap = 0;
        for (int j = 1; j <= 20; j++) begin
            idle1();
            if (scrub_busy_o && (gap == 0)) gap = j;
        end
        check_eq("exp_gap", 32'(gap), 32'(P));

        for (int k = 0; k < 60; k++) begin
            cycle(1'b0, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 15) == 0));
        end
        cycle(1'b0, 1'b0, 4'h0, 1'b1);
        check_eq("clr_cnt", 32'(err_cnt_o), 32'd0);

`ifdef TMR_SCRUB_FAULT_INJ_EN
        wait_phase(0);
        cycle(1'b0, 1'b1, 4'h5, 1'b0);
        inj_v = 1'b1; inj_c = 2'd1; inj_m = 4'h3;
        idle1();
        check_eq("inj_rep", 32'(rep_o), 32'h0000_0565);
        check_eq("inj_vote", 32'(voted_o), 32'h5);
        check_eq("inj_mis", 32'(mismatch_o), 32'd1);
        wait_phase(2);
        idle1();
        check_eq("fix_rep", 32'(rep_o), 32'h0000_0555);
        check_eq("fix_cnt", 32'(err_cnt_o), 32'd1);
        for (int r = 0; r < 3; r++) begin
            inj_v = 1'b1; inj_c = 2'(r); inj_m = 4'hF;
            idle1();
            wait_phase(2);
            idle1();
        end
        check_eq("cnt_sat", 32'(err_cnt_o), 32'd3);
        inj_v = 1'b1; inj_c = 2'd2; inj_m = 4'h1;
        idle1();
        wait_phase(2);
        cycle(1'b0, 1'b0, 4'h0, 1'b1);
        check_eq("clr_in_fix", 32'(err_cnt_o), 32'd1);
        inj_v = 1'b1; inj_c = 2'd3; inj_m = 4'hF;
        idle1();
        check_eq("inj_oob_mis", 32'(mismatch_o), 32'd0);
        // Flip during EVAL must be overwritten by the value captured in EVAL.
        wait_phase(0);
        inj_v = 1'b1; inj_c = 2'd0; inj_m = 4'h1;
        idle1();
        wait_phase(1);
        inj_v = 1'b1; inj_c = 2'd1; inj_m = 4'h2;
        idle1();
        idle1();
        check_eq("eval_flip_fixed", 32'(mismatch_o), 32'd0);
        inj_v = 1'b1; inj_c = 2'd1; inj_m = 4'h4;
        idle1();
`endif
        wait_phase(1);
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        check_eq("rst_eval_rep", 32'(rep_o), 32'd0);
        check_eq("rst_eval_cnt", 32'(err_cnt_o), 32'd0);
        check_eq("rst_eval_ready", 32'(wr_ready_o), 32'd1);
        idle1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
